pc_sequencer: RTL and testbench

//  Parametrised program-counter sequencer for the instruction-fetch stage; next generation of the plain PC register.

---
 rtl/pc_sequencer_if.sv | 29 ++
 rtl/pc_sequencer.sv | 109 ++++++++++
 tb/tb_pc_sequencer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch-stage bus between the PC sequencer and its users: control inputs, fetch PC outputs,
// and the debug history read port.
interface pc_sequencer_if #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned HIST_DEPTH = 8
) ();
   localparam int unsigned IDX_W = $clog2(HIST_DEPTH);

   logic             stall;
   logic             redirectValid;
   logic [WIDTH-1:0] redirectTarget;
   logic             exceptionValid;
   logic [WIDTH-1:0] pcOut;
   logic [WIDTH-1:0] pcNext;
   logic             pcValid;
   logic             misalignFault;
   logic [IDX_W-1:0] histIndex;
   logic [WIDTH-1:0] histPc;

   modport master (
      output stall, redirectValid, redirectTarget, exceptionValid, histIndex,
      input  pcOut, pcNext, pcValid, misalignFault, histPc
   );

   modport slave (
      input  stall, redirectValid, redirectTarget, exceptionValid, histIndex,
      output pcOut, pcNext, pcValid, misalignFault, histPc
   );
endinterface

// File: rtl/pc_sequencer.sv
// Instruction-fetch PC sequencer: BOOT/RUN/FAULT with exception > redirect > stall > increment.
// Define PC_HISTORY_EN to keep a circular history of previous fetch PCs for debug.
module pc_sequencer #(
   parameter int unsigned      WIDTH        = 32,
   parameter int unsigned      INSTR_BYTES  = 4,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0080),
   parameter int unsigned      HIST_DEPTH   = 8
) (
   input logic           clk,
   input logic           reset,
   pc_sequencer_if.slave bus
);
   localparam int unsigned      IDX_W      = $clog2(HIST_DEPTH);
   localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INSTR_BYTES - 1);
   localparam logic [WIDTH-1:0] INC        = WIDTH'(INSTR_BYTES);

   typedef enum logic [1:0] {StBoot, StRun, StFault} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic             valid_q, fault_q;
   logic             misaligned;

   // Mask form stays valid when INSTR_BYTES == 1 (mask is zero, never misaligned).
   assign misaligned = |(bus.redirectTarget & ALIGN_MASK);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      if (reset) begin
         state_d = StBoot;
         pc_d    = RESET_VECTOR;
      end else begin
         case (state_q)
            StBoot: begin
               state_d = StRun;
               pc_d    = RESET_VECTOR;
            end
            StRun: begin
               if (bus.exceptionValid) begin
                  pc_d = EXC_VECTOR;
               end else if (bus.redirectValid && misaligned) begin
                  state_d = StFault;
               end else if (bus.redirectValid) begin
                  pc_d = bus.redirectTarget;
               end else if (!bus.stall) begin
                  pc_d = pc_q + INC;
               end
            end
            StFault: begin
               if (bus.exceptionValid) begin
                  state_d = StRun;
                  pc_d    = EXC_VECTOR;
               end
            end
            default: begin
               state_d = StBoot;
               pc_d    = RESET_VECTOR;
            end
         endcase
      end
   end

   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StBoot;
         pc_q    <= RESET_VECTOR;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         valid_q <= (state_d == StRun);
         fault_q <= (state_d == StFault);
      end
   end

   assign bus.pcOut         = pc_q;
   assign bus.pcNext        = pc_d;
   assign bus.pcValid       = valid_q;
   assign bus.misalignFault = fault_q;

`ifdef PC_HISTORY_EN
   logic [WIDTH-1:0] hist_q [HIST_DEPTH];
   logic [IDX_W-1:0] wp_q;
   logic [IDX_W-1:0] rd_idx;

   // Only RUN-state edges that actually move the PC record the old value.
   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         wp_q <= '0;
         for (int i = 0; i < int'(HIST_DEPTH); i++) begin
            hist_q[i] <= '0;
         end
      end else if (state_q == StRun && pc_d != pc_q) begin
         hist_q[wp_q] <= pc_q;
         wp_q         <= wp_q + 1'b1;
      end
   end

   assign rd_idx     = wp_q - IDX_W'(1) - bus.histIndex;
   assign bus.histPc = hist_q[rd_idx];
`else
   logic unused_hist_index;
   assign unused_hist_index = ^bus.histIndex;
   assign bus.histPc        = '0;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand sequences, and randomized
// stimulus against a rule-level model. History checks follow PC_HISTORY_EN.
module tb_pc_sequencer;
   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;

   always #10 clk = ~clk;

   pc_sequencer_if #(.WIDTH(32), .HIST_DEPTH(4)) bus ();
   pc_sequencer_if #(.WIDTH(8),  .HIST_DEPTH(4)) bus8 ();

   pc_sequencer #(
      .WIDTH(32), .INSTR_BYTES(4), .RESET_VECTOR(32'h0), .EXC_VECTOR(32'h80), .HIST_DEPTH(4)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   pc_sequencer #(
      .WIDTH(8), .INSTR_BYTES(4), .RESET_VECTOR(8'h0), .EXC_VECTOR(8'h80), .HIST_DEPTH(4)
   ) dut8 (
      .clk(clk), .reset(reset), .bus(bus8)
   );

   // Reference model: mode 0 = boot, 1 = run, 2 = fault; history newest first.
   int          m_mode;
   logic [31:0] m_pc;
   logic [31:0] m_hist[$];

   typedef struct {
      bit          st;
      bit          rv;
      logic [31:0] tg;
      bit          ex;
      logic [31:0] pc;
      bit          v;
      bit          f;
   } vec_t;

   vec_t tbl[18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0;
      m_pc   = 32'h0;
      m_hist.delete();
   endtask

   task automatic model_step(input bit st, input bit rv, input logic [31:0] tg, input bit ex);
      logic [31:0] old_pc;
      int          old_mode;
      old_pc   = m_pc;
      old_mode = m_mode;
      if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 1) begin
         if (ex) m_pc = 32'h80;
         else if (rv && (tg % 4) != 0) m_mode = 2;
         else if (rv) m_pc = tg;
         else if (!st) m_pc = m_pc + 32'd4;
      end else if (ex) begin
         m_pc   = 32'h80;
         m_mode = 1;
      end
      if (old_mode == 1 && m_pc != old_pc) begin
         m_hist.push_front(old_pc);
         if (m_hist.size() > 4) void'(m_hist.pop_back());
      end
   endtask

   task automatic check_hist();
      for (int i = 0; i < 4; i++) begin
         logic [31:0] e;
         bus.histIndex = 2'(i);
         #1;
`ifdef PC_HISTORY_EN
         e = (i < m_hist.size()) ? m_hist[i] : 32'h0;
`else
         e = 32'h0;
`endif
         check($sformatf("histPc[%0d]", i), bus.histPc, e);
      end
      bus.histIndex = 2'd0;
   endtask

   // Called right after a posedge; drives, checks pcNext, waits one active edge, checks outputs.
   task automatic apply(input bit st, input bit rv, input logic [31:0] tg, input bit ex);
      bus.stall          = st;
      bus.redirectValid  = rv;
      bus.redirectTarget = tg;
      bus.exceptionValid = ex;
      model_step(st, rv, tg, ex);
      #1;
      check("pcNext", bus.pcNext, m_pc);
      @(negedge clk);
      @(posedge clk);
      check("pcOut", bus.pcOut, m_pc);
      check("pcValid", {31'd0, bus.pcValid}, {31'd0, m_mode == 1});
      check("misalignFault", {31'd0, bus.misalignFault}, {31'd0, m_mode == 2});
      check_hist();
   endtask

   // Asserts reset between edges and checks the immediate effect before any clock edge.
   task automatic do_reset();
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check("rst_pcOut", bus.pcOut, 32'h0);
      check("rst_pcNext", bus.pcNext, 32'h0);
      check("rst_pcValid", {31'd0, bus.pcValid}, 32'd0);
      check("rst_fault", {31'd0, bus.misalignFault}, 32'd0);
      repeat (2) @(posedge clk);
      reset = 1'b0;
      check_hist();
   endtask

   initial begin
      logic [31:0] hexp[4];
      reset               = 1'b1;
      bus.stall           = 1'b0;
      bus.redirectValid   = 1'b0;
      bus.redirectTarget  = 32'h0;
      bus.exceptionValid  = 1'b0;
      bus.histIndex       = 2'd0;
      bus8.stall          = 1'b0;
      bus8.redirectValid  = 1'b0;
      bus8.redirectTarget = 8'h0;
      bus8.exceptionValid = 1'b0;
      bus8.histIndex      = 2'd0;
      model_reset();

      //           st rv  tg            ex  pc            v  f
      tbl[0]  = '{0, 0, 32'h0,        0, 32'h0,        1, 0};
      tbl[1]  = '{0, 0, 32'h0,        0, 32'h4,        1, 0};
      tbl[2]  = '{0, 0, 32'h0,        0, 32'h8,        1, 0};
      tbl[3]  = '{0, 0, 32'h0,        0, 32'hC,        1, 0};
      tbl[4]  = '{0, 0, 32'h0,        0, 32'h10,       1, 0};
      tbl[5]  = '{1, 0, 32'h0,        0, 32'h10,       1, 0};
      tbl[6]  = '{1, 0, 32'h0,        0, 32'h10,       1, 0};
      tbl[7]  = '{1, 0, 32'h0,        0, 32'h10,       1, 0};
      tbl[8]  = '{1, 1, 32'h200,      0, 32'h200,      1, 0};
      tbl[9]  = '{0, 0, 32'h0,        0, 32'h204,      1, 0};
      tbl[10] = '{0, 1, 32'h102,      0, 32'h204,      0, 1};
      tbl[11] = '{1, 0, 32'h0,        0, 32'h204,      0, 1};
      tbl[12] = '{0, 1, 32'h300,      0, 32'h204,      0, 1};
      tbl[13] = '{1, 1, 32'h301,      1, 32'h80,       1, 0};
      tbl[14] = '{0, 1, 32'h300,      1, 32'h80,       1, 0};
      tbl[15] = '{0, 0, 32'h0,        0, 32'h84,       1, 0};
      tbl[16] = '{0, 1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 1, 0};
      tbl[17] = '{0, 0, 32'h0,        0, 32'h0,        1, 0};

      repeat (2) @(posedge clk);
      check("init_pcOut", bus.pcOut, 32'h0);
      check("init_pcValid", {31'd0, bus.pcValid}, 32'd0);
      check("init_fault", {31'd0, bus.misalignFault}, 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 18; i++) begin
         apply(tbl[i].st, tbl[i].rv, tbl[i].tg, tbl[i].ex);
         check($sformatf("tbl%0d_pc", i), bus.pcOut, tbl[i].pc);
         check($sformatf("tbl%0d_valid", i), {31'd0, bus.pcValid}, {31'd0, tbl[i].v});
         check($sformatf("tbl%0d_fault", i), {31'd0, bus.misalignFault}, {31'd0, tbl[i].f});
      end

      // Mid-run async reset; exception held through BOOT must be ignored.
      do_reset();
      apply(0, 0, 32'h0, 1);
      check("boot_ignores_exc", bus.pcOut, 32'h0);
      apply(0, 0, 32'h0, 1);
      check("exc_after_boot", bus.pcOut, 32'h80);

      // History: run 0x0..0x18, then stalls add nothing.
      do_reset();
      for (int i = 0; i < 7; i++) apply(0, 0, 32'h0, 0);
      check("hist_run_pc", bus.pcOut, 32'h18);
      apply(1, 0, 32'h0, 0);
      apply(1, 0, 32'h0, 0);
      hexp = '{32'h14, 32'h10, 32'hC, 32'h8};
      for (int i = 0; i < 4; i++) begin
         bus.histIndex = 2'(i);
         #1;
`ifdef PC_HISTORY_EN
         check($sformatf("hist_fixed[%0d]", i), bus.histPc, hexp[i]);
`else
         check($sformatf("hist_tied[%0d]", i), bus.histPc, 32'h0);
`endif
      end
      bus.histIndex = 2'd0;

      for (int n = 0; n < 400; n++) begin
         bit          st, rv, ex;
         logic [31:0] tg;
         if ($urandom_range(0, 63) == 0) do_reset();
         st = ($urandom_range(0, 3) == 0);
         rv = ($urandom_range(0, 4) == 0);
         ex = ($urandom_range(0, 15) == 0);
         tg = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 5) == 0) tg = tg | 32'($urandom_range(1, 3));
         apply(st, rv, tg, ex);
      end

      // 8-bit instance: wrap from 0xFC to 0x00 without a flag.
      bus8.redirectValid  = 1'b1;
      bus8.redirectTarget = 8'hFC;
      @(negedge clk);
      @(posedge clk);
      check("w8_redirect", {24'd0, bus8.pcOut}, 32'hFC);
      bus8.redirectValid = 1'b0;
      #1;
      check("w8_pcNext_wrap", {24'd0, bus8.pcNext}, 32'h0);
      @(negedge clk);
      @(posedge clk);
      check("w8_wrap", {24'd0, bus8.pcOut}, 32'h0);
      check("w8_valid", {31'd0, bus8.pcValid}, 32'd1);
      check("w8_fault", {31'd0, bus8.misalignFault}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
